// File: rtl/sr_config_sequencer_pkg.sv
// Shared types and defaults for the divider/rowsize configuration sequencer.
package sr_config_sequencer_pkg;

  localparam int SR_WIDTH_DEF = 16;
  localparam int HALF_PER_DEF = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_CLEAR,
    ST_SEL_DIV,
    ST_SHIFT_DIV,
    ST_DESEL_DIV,
    ST_SEL_ROW,
    ST_SHIFT_ROW,
    ST_DESEL_ROW,
    ST_ENABLE
  } state_t;

endpackage

// File: rtl/sr_config_sequencer_serializer.sv
// sr_serializer: shifts one word out MSB first, each bit a LOW then HIGH sr_clk phase
// of HALF_PER cycles; o_last flags the final cycle of the last HIGH phase.
module sr_serializer #(
  parameter int SR_WIDTH = 16,
  parameter int HALF_PER = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [SR_WIDTH-1:0] i_word,
  output logic                o_sr_clk,
  output logic                o_sr_data,
  output logic                o_last
);
  localparam int BW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

  logic [SR_WIDTH-1:0] r_shreg;
  logic [BW-1:0]       r_bit;
  logic [7:0]          r_phase;
  logic                r_high;
  logic                r_active;
  logic                w_phase_end;

  assign w_phase_end = (r_phase == 8'(HALF_PER - 1));
  assign o_last      = r_active & r_high & w_phase_end & (r_bit == BW'(SR_WIDTH - 1));
  assign o_sr_clk    = r_active & r_high;
  assign o_sr_data   = r_active & r_shreg[SR_WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg  <= '0;
      r_bit    <= '0;
      r_phase  <= '0;
      r_high   <= 1'b0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_shreg  <= i_word;
      r_bit    <= '0;
      r_phase  <= '0;
      r_high   <= 1'b0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (!w_phase_end) begin
        r_phase <= r_phase + 8'd1;
      end else begin
        r_phase <= '0;
        r_high  <= ~r_high;
        if (r_high) begin
          r_shreg <= r_shreg << 1;
          if (o_last) begin
            r_active <= 1'b0;
            r_bit    <= '0;
          end else begin
            r_bit <= r_bit + BW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/sr_config_sequencer.sv
// Loads divider (and, with ROWPACK_CFG_EN defined, rowsize) shift registers over a
// serial bus, quiescing the divider during the load and re-enabling it afterwards.
module sr_config_sequencer
  import sr_config_sequencer_pkg::*;
#(
  parameter int SR_WIDTH = SR_WIDTH_DEF,
  parameter int HALF_PER = HALF_PER_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [SR_WIDTH-1:0] cfg_divider,
  input  logic [SR_WIDTH-1:0] cfg_rowsize,
  input  logic                cfg_clear,
  input  logic                run_en,
  output logic                sr_data,
  output logic                sr_clk,
  output logic                sr_sel_div,
  output logic                sr_clr_div,
  output logic                sr_sel_row,
  output logic                sr_clr_row,
  output logic                divide_enable,
  output logic                en_internals,
  output logic                busy,
  output logic                done
);
  state_t              r_state, w_next;
  logic [7:0]          r_cnt;
  logic [SR_WIDTH-1:0] r_div;
  logic                r_clear, r_run, r_en, r_done;
  logic                w_tick, w_accept;
  logic                w_ser_start, w_ser_clk, w_ser_data, w_ser_last;
  logic [SR_WIDTH-1:0] w_ser_word;

`ifdef ROWPACK_CFG_EN
  logic [SR_WIDTH-1:0] r_row;
`else
  logic w_unused_rowsize;
  assign w_unused_rowsize = ^cfg_rowsize;
`endif

  assign w_tick   = (r_cnt == 8'(HALF_PER - 1));
  assign w_accept = cfg_valid && (r_state == ST_IDLE);

  // Captured config and the enable register are cleared by reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_clear <= 1'b0;
      r_run   <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
`ifdef ROWPACK_CFG_EN
      r_row   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_ENABLE);
      if (w_next != r_state) r_cnt <= '0;
      else if (!w_tick)      r_cnt <= r_cnt + 8'd1;
      if (w_accept) begin
        r_div   <= cfg_divider;
        r_clear <= cfg_clear;
        r_run   <= run_en;
        r_en    <= 1'b0;
`ifdef ROWPACK_CFG_EN
        r_row   <= cfg_rowsize;
`endif
      end else if (w_next == ST_ENABLE && r_state != ST_ENABLE) begin
        r_en <= r_run && (r_div != '0);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_ser_start = 1'b0;
    w_ser_word  = r_div;
    case (r_state)
      ST_IDLE:      if (cfg_valid) w_next = ST_QUIESCE;
      ST_QUIESCE:   if (w_tick) w_next = r_clear ? ST_CLEAR : ST_SEL_DIV;
      ST_CLEAR:     if (w_tick) w_next = ST_SEL_DIV;
      ST_SEL_DIV: begin
        if (w_tick) begin
          w_next      = ST_SHIFT_DIV;
          w_ser_start = 1'b1;
        end
      end
      ST_SHIFT_DIV: if (w_ser_last) w_next = ST_DESEL_DIV;
`ifdef ROWPACK_CFG_EN
      ST_DESEL_DIV: if (w_tick) w_next = ST_SEL_ROW;
      ST_SEL_ROW: begin
        if (w_tick) begin
          w_next      = ST_SHIFT_ROW;
          w_ser_start = 1'b1;
          w_ser_word  = r_row;
        end
      end
      ST_SHIFT_ROW: if (w_ser_last) w_next = ST_DESEL_ROW;
      ST_DESEL_ROW: if (w_tick) w_next = ST_ENABLE;
`else
      ST_DESEL_DIV: if (w_tick) w_next = ST_ENABLE;
`endif
      ST_ENABLE:    w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  sr_serializer #(
    .SR_WIDTH (SR_WIDTH),
    .HALF_PER (HALF_PER)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_ser_start),
    .i_word    (w_ser_word),
    .o_sr_clk  (w_ser_clk),
    .o_sr_data (w_ser_data),
    .o_last    (w_ser_last)
  );

  assign cfg_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign divide_enable = r_en;
  assign en_internals  = r_en;
  assign sr_sel_div    = (r_state == ST_SEL_DIV) || (r_state == ST_SHIFT_DIV);
  assign sr_clr_div    = (r_state == ST_CLEAR);
`ifdef ROWPACK_CFG_EN
  assign sr_sel_row    = (r_state == ST_SEL_ROW) || (r_state == ST_SHIFT_ROW);
  assign sr_clr_row    = (r_state == ST_CLEAR);
`else
  assign sr_sel_row    = 1'b0;
  assign sr_clr_row    = 1'b0;
`endif
  assign sr_clk        = w_ser_clk;
  assign sr_data       = (sr_sel_div | sr_sel_row) & w_ser_data;

endmodule
